truth_table_sweeper: RTL and testbench

Sequencer that exhaustively exercises the three-input combinational circuit (inputs x2, x1, x0; output z) in hardware. On `start` it drives all eight input vectors in ascending order and holds each for a programmable settle time. It samples `z` into an 8-bit captured truth table and compares the result against a golden table. It sits between the board-level control and the circuit under test, replacing the manual vector-by-vector bench procedure with a self-checking on-chip sweep.

---
 rtl/truth_table_sweeper.sv | 146 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps a 3-input circuit under test through all eight
// input vectors, holds each one for a programmable settle time, captures z
// into an 8-bit truth table and compares the capture against a golden table.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       z,
    output logic       x2,
    output logic       x1,
    output logic       x0,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic       pass,
    output logic [2:0] first_fail
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned TT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_FINISH
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TT_W-1:0]  exp_q;
    logic [TT_W-1:0]  tt_q;
    logic [IDX_W-1:0] x_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [IDX_W-1:0] ff_q;

    logic [TT_W-1:0]  tt_d;
    logic [TT_W-1:0]  diff_d;
    logic             pass_d;
    logic [IDX_W-1:0] ff_d;

    // Table as it will look after the current sample, and its verdict against the golden table
    always_comb begin
        tt_d        = tt_q;
        tt_d[idx_q] = z;
        diff_d      = tt_d ^ exp_q;
        pass_d      = (diff_d == '0);
        ff_d        = '0;
        for (int i = int'(TT_W) - 1; i >= 0; i--) begin
            if (diff_d[i]) begin
                ff_d = IDX_W'(i);
            end
        end
    end

    // Sweep sequencer: state, counters, capture and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            x_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            ff_q    <= '0;
        end else if (state_q != S_IDLE && abort) begin
            // partial capture in tt_q is deliberately kept
            state_q <= S_IDLE;
            x_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            ff_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start && !abort) begin
                        exp_q   <= expected;
                        tt_q    <= '0;
                        pass_q  <= 1'b0;
                        ff_q    <= '0;
                        idx_q   <= '0;
                        cnt_q   <= CNT_LOAD;
                        x_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    tt_q <= tt_d;
                    if (idx_q == IDX_LAST) begin
                        pass_q  <= pass_d;
                        ff_q    <= ff_d;
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        x_q     <= idx_q + IDX_W'(1);
                        cnt_q   <= CNT_LOAD;
                        state_q <= S_SETTLE;
                    end
                end
                S_FINISH: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    x_q     <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign x2          = x_q[2];
    assign x1          = x_q[1];
    assign x0          = x_q[0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = tt_q;
    assign pass        = pass_q;
    assign first_fail  = ff_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 4 driving a majority
// circuit, settle 1 with z tied high), table-driven sweeps plus hand-written
// abort, restart, reset and start/abort-collision sequences.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance 0: SETTLE_CYCLES = 4, majority circuit
    logic       start0, abort0, z0;
    logic [7:0] exp0;
    logic       x2_0, x1_0, x0_0, busy0, done0, pass0;
    logic [7:0] tt0;
    logic [2:0] ff0;

    // instance 1: SETTLE_CYCLES = 1, z tied high
    logic       start1, abort1, z1;
    logic [7:0] exp1;
    logic       x2_1, x1_1, x0_1, busy1, done1, pass1;
    logic [7:0] tt1;
    logic [2:0] ff1;

    assign z0 = (x2_0 & x1_0) | (x2_0 & x0_0) | (x1_0 & x0_0);
    assign z1 = 1'b1;

    truth_table_sweeper #(.SETTLE_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .expected(exp0), .z(z0),
        .x2(x2_0), .x1(x1_0), .x0(x0_0), .busy(busy0), .done(done0),
        .truth_table(tt0), .pass(pass0), .first_fail(ff0)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .expected(exp1), .z(z1),
        .x2(x2_1), .x1(x1_1), .x0(x0_1), .busy(busy1), .done(done1),
        .truth_table(tt1), .pass(pass1), .first_fail(ff1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int         dut;
        logic [7:0] expv;
        logic [7:0] tt;
        logic       pass;
        logic [2:0] ff;
        int         restart_k;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, req, $time);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] x_of(input int d);
        return (d == 0) ? {x2_0, x1_0, x0_0} : {x2_1, x1_1, x0_1};
    endfunction
    function automatic logic busy_of(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction
    function automatic logic done_of(input int d);
        return (d == 0) ? done0 : done1;
    endfunction
    function automatic logic pass_of(input int d);
        return (d == 0) ? pass0 : pass1;
    endfunction
    function automatic logic [7:0] tt_of(input int d);
        return (d == 0) ? tt0 : tt1;
    endfunction
    function automatic logic [2:0] ff_of(input int d);
        return (d == 0) ? ff0 : ff1;
    endfunction

    task automatic set_in(input int d, input logic s, input logic a, input logic [7:0] e);
        if (d == 0) begin
            start0 = s; abort0 = a; exp0 = e;
        end else begin
            start1 = s; abort1 = a; exp1 = e;
        end
    endtask

    task automatic set_start(input int d, input logic s);
        if (d == 0) start0 = s;
        else start1 = s;
    endtask

    task automatic set_abort(input int d, input logic a);
        if (d == 0) abort0 = a;
        else abort1 = a;
    endtask

    task automatic set_exp(input int d, input logic [7:0] e);
        if (d == 0) exp0 = e;
        else exp1 = e;
    endtask

    // pulse start; returns positioned in cycle 1 (first SETTLE cycle)
    task automatic kick(input int d, input logic [7:0] e);
        set_in(d, 1'b1, 1'b0, e);
        step();
        set_start(d, 1'b0);
    endtask

    // full sweep with per-cycle x/done/busy checks and final verdict checks
    task automatic run_sweep(input vec_t v);
        int per;
        int n;
        int xe;
        per = (v.dut == 0) ? 5 : 2;
        n   = 8 * per + 1;
        kick(v.dut, v.expv);
        for (int k = 1; k <= n; k++) begin
            xe = (k == n) ? 7 : (k - 1) / per;
            check($sformatf("x_d%0d_k%0d", v.dut, k), 8'(x_of(v.dut)), 8'(xe));
            check($sformatf("done_d%0d_k%0d", v.dut, k), 8'(done_of(v.dut)), 8'(k == n));
            check($sformatf("busy_d%0d_k%0d", v.dut, k), 8'(busy_of(v.dut)), 8'd1);
            if (k == n) begin
                check("truth_table", tt_of(v.dut), v.tt);
                check("pass", 8'(pass_of(v.dut)), 8'(v.pass));
                check("first_fail", 8'(ff_of(v.dut)), 8'(v.ff));
            end
            if (v.restart_k > 0 && k == v.restart_k) begin
                set_start(v.dut, 1'b1);
                set_exp(v.dut, 8'h00);
            end else if (v.restart_k > 0 && k == v.restart_k + 1) begin
                set_start(v.dut, 1'b0);
            end
            step();
        end
        check("busy_after", 8'(busy_of(v.dut)), 8'd0);
        check("done_after", 8'(done_of(v.dut)), 8'd0);
        check("x_after", 8'(x_of(v.dut)), 8'd0);
        check("pass_held", 8'(pass_of(v.dut)), 8'(v.pass));
        check("tt_held", tt_of(v.dut), v.tt);
        check("ff_held", 8'(ff_of(v.dut)), 8'(v.ff));
    endtask

    // abort in cycle kab while vector 3 is applied
    task automatic abort_test(input int d, input logic [7:0] e, input int kab, input logic [7:0] tt_req);
        int dones;
        kick(d, e);
        for (int k = 1; k < kab; k++) step();
        check("x_before_abort", 8'(x_of(d)), 8'd3);
        set_abort(d, 1'b1);
        step();
        set_abort(d, 1'b0);
        check("abort_busy", 8'(busy_of(d)), 8'd0);
        check("abort_x", 8'(x_of(d)), 8'd0);
        check("abort_done", 8'(done_of(d)), 8'd0);
        check("abort_pass", 8'(pass_of(d)), 8'd0);
        check("abort_ff", 8'(ff_of(d)), 8'd0);
        check("abort_tt", tt_of(d), tt_req);
        dones = 0;
        for (int k = 0; k < 45; k++) begin
            if (done_of(d) !== 1'b0 || busy_of(d) !== 1'b0) dones++;
            step();
        end
        check("abort_no_done", 8'(dones), 8'd0);
    endtask

    task automatic check_reset_vals(input int d);
        check($sformatf("rst_x_d%0d", d), 8'(x_of(d)), 8'd0);
        check($sformatf("rst_busy_d%0d", d), 8'(busy_of(d)), 8'd0);
        check($sformatf("rst_done_d%0d", d), 8'(done_of(d)), 8'd0);
        check($sformatf("rst_pass_d%0d", d), 8'(pass_of(d)), 8'd0);
        check($sformatf("rst_tt_d%0d", d), tt_of(d), 8'h00);
        check($sformatf("rst_ff_d%0d", d), 8'(ff_of(d)), 8'd0);
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{dut: 0, expv: 8'hE8, tt: 8'hE8, pass: 1'b1, ff: 3'd0, restart_k: 0};
        vecs[1] = '{dut: 0, expv: 8'hEC, tt: 8'hE8, pass: 1'b0, ff: 3'd2, restart_k: 0};
        vecs[2] = '{dut: 0, expv: 8'h68, tt: 8'hE8, pass: 1'b0, ff: 3'd7, restart_k: 0};
        vecs[3] = '{dut: 0, expv: 8'hA8, tt: 8'hE8, pass: 1'b0, ff: 3'd6, restart_k: 0};
        vecs[4] = '{dut: 0, expv: 8'hE8, tt: 8'hE8, pass: 1'b1, ff: 3'd0, restart_k: 22};
        vecs[5] = '{dut: 1, expv: 8'hFF, tt: 8'hFF, pass: 1'b1, ff: 3'd0, restart_k: 0};
        vecs[6] = '{dut: 1, expv: 8'h00, tt: 8'hFF, pass: 1'b0, ff: 3'd0, restart_k: 0};
        vecs[7] = '{dut: 1, expv: 8'h7F, tt: 8'hFF, pass: 1'b0, ff: 3'd7, restart_k: 0};

        rst = 1'b1;
        set_in(0, 1'b0, 1'b0, 8'h00);
        set_in(1, 1'b0, 1'b0, 8'h00);
        step();
        step();
        rst = 1'b0;
        check_reset_vals(0);
        check_reset_vals(1);

        for (int i = 0; i < 8; i++) begin
            run_sweep(vecs[i]);
            step();
        end

        // abort mid-sweep: majority keeps 8'h00, z-high keeps bits 0..2
        abort_test(0, 8'hE8, 17, 8'h00);
        abort_test(1, 8'hFF, 7, 8'h07);

        // reset during SAMPLE of vector 5 (cycle 30), then a clean sweep
        kick(0, 8'hE8);
        for (int k = 1; k < 30; k++) step();
        check("x_before_rst", 8'(x_of(0)), 8'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_vals(0);
        rv = vecs[0];
        run_sweep(rv);
        step();

        // start and abort together in IDLE: nothing happens
        set_in(1, 1'b1, 1'b1, 8'hFF);
        step();
        set_in(1, 1'b0, 1'b0, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            check("collide_busy", 8'(busy1), 8'd0);
            check("collide_x", 8'(x_of(1)), 8'd0);
            check("collide_done", 8'(done1), 8'd0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
